iob_cache_perf_ctrl: RTL



---
 rtl/iob_cache_perf_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/iob_cache_perf_ctrl.sv
// Cache control / performance monitor: per-port saturating hit/miss counters with
// snapshot shadows, cache status and invalidate control behind a word-addressed register port.
module iob_cache_perf_ctrl #(
    parameter int          N_PORTS = 2,
    parameter int          CNT_W   = 32,
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 4,
    parameter logic [15:0] VERSION = 16'h0200
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic               wen_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [DATA_W-1:0]  rdata_o,
    output logic               ready_o,
    output logic               invalidate_o,
    input  logic               wtbuf_empty_i,
    input  logic               wtbuf_full_i,
    input  logic [N_PORTS-1:0] read_hit_i,
    input  logic [N_PORTS-1:0] read_miss_i,
    input  logic [N_PORTS-1:0] write_hit_i,
    input  logic [N_PORTS-1:0] write_miss_i
);
    localparam int SUM_W = CNT_W + 1 + $clog2(N_PORTS);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_PSEL    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_RH      = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_RM      = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_WH      = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_WM      = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_HIT     = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] A_MISS    = ADDR_W'(9);

    logic                     enable_reg;
    logic                     sat_reg;
    logic [DATA_W-1:0]        psel_reg;
    logic                     wr_acc, ctrl_wr, clear_cmd, snap_cmd;
    logic [N_PORTS-1:0]       sat_evt;
    logic [3:0][CNT_W-1:0]    shadow [N_PORTS];
    logic [3:0][CNT_W-1:0]    sel_cnt;
    logic                     sel_ok;
    logic [SUM_W-1:0]         hit_sum, miss_sum;
    logic [CNT_W-1:0]         hit_total, miss_total;
    logic [DATA_W-1:0]        rd_data;

    assign wr_acc    = valid_i && wen_i;
    assign ctrl_wr   = wr_acc && (addr_i == A_CTRL);
    assign clear_cmd = ctrl_wr && wdata_i[1];
    assign snap_cmd  = ctrl_wr && wdata_i[2];

    // Counter index k: 0 = read hit, 1 = read miss, 2 = write hit, 3 = write miss.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        logic [3:0]            evt;
        logic [3:0]            near_max;
        logic [3:0][CNT_W-1:0] live_reg;
        logic [3:0][CNT_W-1:0] shadow_reg;

        assign evt = {write_miss_i[gi], write_hit_i[gi], read_miss_i[gi], read_hit_i[gi]};

        for (genvar gk = 0; gk < 4; gk++) begin : g_cnt
            assign near_max[gk] = (live_reg[gk] >= CNT_MAX - 1'b1);
        end

        // An accepted event that lands on (or is blocked at) the maximum marks saturation.
        assign sat_evt[gi] = enable_reg && |(evt & near_max);
        assign shadow[gi]  = shadow_reg;

        always_ff @(posedge clk_i) begin
            if (reset_i || clear_cmd) begin
                live_reg   <= '0;
                shadow_reg <= '0;
            end else begin
                // Shadows take the pre-edge live value; same-cycle events only reach live.
                if (snap_cmd) shadow_reg <= live_reg;
                for (int k = 0; k < 4; k++) begin
                    if (enable_reg && evt[k] && (live_reg[k] != CNT_MAX))
                        live_reg[k] <= live_reg[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit_sum  = '0;
        miss_sum = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            hit_sum  = hit_sum  + SUM_W'(shadow[p][0]) + SUM_W'(shadow[p][2]);
            miss_sum = miss_sum + SUM_W'(shadow[p][1]) + SUM_W'(shadow[p][3]);
        end
        hit_total  = (hit_sum  > SUM_W'(CNT_MAX)) ? CNT_MAX : hit_sum[CNT_W-1:0];
        miss_total = (miss_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : miss_sum[CNT_W-1:0];
    end

    // Out-of-range port selections read as zero rather than aliasing onto a real port.
    assign sel_ok = (psel_reg < DATA_W'(N_PORTS));

    always_comb begin
        sel_cnt = '0;
        if (sel_ok) sel_cnt = shadow[psel_reg[IDX_W-1:0]];
        rd_data = '0;
        case (addr_i)
            A_VERSION: rd_data = DATA_W'(VERSION);
            A_STATUS:  rd_data[3:0] = {sat_reg, enable_reg, wtbuf_full_i, wtbuf_empty_i};
            A_PSEL:    rd_data = psel_reg;
            A_RH:      rd_data[CNT_W-1:0] = sel_cnt[0];
            A_RM:      rd_data[CNT_W-1:0] = sel_cnt[1];
            A_WH:      rd_data[CNT_W-1:0] = sel_cnt[2];
            A_WM:      rd_data[CNT_W-1:0] = sel_cnt[3];
            A_HIT:     rd_data[CNT_W-1:0] = hit_total;
            A_MISS:    rd_data[CNT_W-1:0] = miss_total;
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ready_o      <= 1'b0;
            invalidate_o <= 1'b0;
            rdata_o      <= '0;
            enable_reg   <= 1'b1;
            sat_reg      <= 1'b0;
            psel_reg     <= '0;
        end else begin
            ready_o      <= valid_i;
            rdata_o      <= (valid_i && !wen_i) ? rd_data : '0;
            invalidate_o <= ctrl_wr && wdata_i[0];
            if (ctrl_wr && wdata_i[3]) enable_reg <= wdata_i[4];
            if (wr_acc && (addr_i == A_PSEL)) psel_reg <= wdata_i;
            if (clear_cmd)     sat_reg <= 1'b0;
            else if (|sat_evt) sat_reg <= 1'b1;
        end
    end
endmodule
